// File: rtl/alta_bram_arb.sv
// alta_bram_arb
//   Two-client round-robin arbiter and sequencer for one port of an alta_bram.
//   Serialises client reads/writes onto the BRAM's single address/data/WeRen
//   port. It tracks read latency so that read data is returned to the client
//   that asked for it. It can also zero-fill the RAM after reset.
//
//   Optional feature: define ALTA_BRAM_ARB_STATS_EN to add a saturating
//   16-bit conflict counter (ConflictCnt) with a synchronous clear
//   (ConflictClr).
//
// Ports
//   Clk, AsyncResetN        clock, asynchronous active-low reset
//   Req/We/Addr/WData[0,1]  client requests, held stable until granted
//   Gnt0, Gnt1              combinational grant, same cycle as the request
//   RValid0, RValid1        read data valid for client 0 / 1
//   RData                   shared read data, qualified by RValid0/RValid1
//   BramAddr/BramDataIn/BramWeRen/BramClkEn  drive to BRAM port A
//   BramDataOut             BRAM port A read data
//   Busy                    high while the post-reset clear sweep runs
//   ConflictClr/ConflictCnt (ALTA_BRAM_ARB_STATS_EN only) conflict statistics

module alta_bram_arb #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 18,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter int DEPTH          = 4096
) (
    input  logic              Clk,
    input  logic              AsyncResetN,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              We0,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData0,
    input  logic [DATA_W-1:0] WData1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              RValid0,
    output logic              RValid1,
    output logic [DATA_W-1:0] RData,
    output logic [ADDR_W-1:0] BramAddr,
    output logic [DATA_W-1:0] BramDataIn,
    output logic              BramWeRen,
    output logic              BramClkEn,
    input  logic [DATA_W-1:0] BramDataOut,
    output logic              Busy
`ifdef ALTA_BRAM_ARB_STATS_EN
    ,
    input  logic              ConflictClr,
    output logic [15:0]       ConflictCnt
`endif
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t            RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   sweep_cnt;
    logic                last_gnt;     // 1: client 1 was granted most recently
    logic [ADDR_W-1:0]   addr_hold;
    logic [DATA_W-1:0]   data_hold;
    logic [READ_LAT-1:0] rd_vld_p;     // index = cycles since the read grant, minus one
    logic [READ_LAT-1:0] rd_id_p;

    always_ff @(posedge Clk or negedge AsyncResetN) begin
        if (!AsyncResetN) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // The grant and the BRAM strobes are combinational. They are gated with the
    // reset input so that every output shows its reset value as soon as reset is
    // asserted, not only at the next clock edge.
    always_comb begin
        state_nxt  = state;
        Gnt0       = 1'b0;
        Gnt1       = 1'b0;
        BramClkEn  = 1'b0;
        BramWeRen  = 1'b0;
        BramAddr   = addr_hold;
        BramDataIn = data_hold;
        Busy       = 1'b0;
        case (state)
            ST_INIT: begin
                Busy = 1'b1;
                if (AsyncResetN) begin
                    BramClkEn  = 1'b1;
                    BramWeRen  = 1'b1;
                    BramAddr   = sweep_cnt;
                    BramDataIn = '0;
                end
                if (sweep_cnt == LAST_ADDR) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (AsyncResetN) begin
                    // On a conflict, client 0 wins unless it had the last grant.
                    if (Req0 && (!Req1 || last_gnt)) begin
                        Gnt0       = 1'b1;
                        BramClkEn  = 1'b1;
                        BramWeRen  = We0;
                        BramAddr   = Addr0;
                        BramDataIn = WData0;
                    end else if (Req1) begin
                        Gnt1       = 1'b1;
                        BramClkEn  = 1'b1;
                        BramWeRen  = We1;
                        BramAddr   = Addr1;
                        BramDataIn = WData1;
                    end
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge Clk or negedge AsyncResetN) begin
        if (!AsyncResetN) begin
            sweep_cnt <= '0;
            last_gnt  <= 1'b1;
            addr_hold <= '0;
            data_hold <= '0;
            rd_vld_p  <= '0;
            rd_id_p   <= '0;
        end else begin
            if (state == ST_INIT) begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end
            if (Gnt0 || Gnt1) begin
                last_gnt <= Gnt1;
            end
            // Address/data keep their last driven values while the BRAM is idle.
            if (BramClkEn) begin
                addr_hold <= BramAddr;
                data_hold <= BramDataIn;
            end
            // Read-return pipeline: stage 0 is loaded at the grant edge.
            rd_vld_p[0] <= (Gnt0 || Gnt1) && !BramWeRen;
            rd_id_p[0]  <= Gnt1;
            for (int i = 1; i < READ_LAT; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
                rd_id_p[i]  <= rd_id_p[i-1];
            end
        end
    end

    // The last pipeline stage lines up with BRAM data for that read.
    assign RValid0 = rd_vld_p[READ_LAT-1] && !rd_id_p[READ_LAT-1];
    assign RValid1 = rd_vld_p[READ_LAT-1] &&  rd_id_p[READ_LAT-1];
    assign RData   = rd_vld_p[READ_LAT-1] ? BramDataOut : '0;

`ifdef ALTA_BRAM_ARB_STATS_EN
    always_ff @(posedge Clk or negedge AsyncResetN) begin
        if (!AsyncResetN) begin
            ConflictCnt <= '0;
        end else if (ConflictClr) begin
            ConflictCnt <= '0;
        end else if ((state == ST_RUN) && Req0 && Req1 && (ConflictCnt != 16'hFFFF)) begin
            ConflictCnt <= ConflictCnt + 16'd1;
        end
    end
`else
    // No conflict statistics in this build.
`endif

endmodule

// File: doc/alta_bram_arb.md
Name: alta_bram_arb

Overview:
- Two-requester round-robin arbiter and sequencer for one port of an alta_bram block.
- Serialises read/write requests from two clients onto the BRAM's single address/data/WeRen port.
- Tracks read latency so each client gets its own read data back.
- Optionally zero-fills the RAM after reset.
- Sits between client logic and the alta_bram instance. Clients never drive the BRAM directly.

Parameters:
- ADDR_W, 12, address width; matches the BRAM AddressA width.
- DATA_W, 18, data width; matches the BRAM DataInA/DataOutA width.
- READ_LAT, 1, BRAM read latency in cycles: 1 when PORTA_OUTREG=0, 2 when PORTA_OUTREG=1. Legal values: 1, 2.
- CLEAR_ON_RESET, 1, 1 = sweep-write zeros to every address after reset; 0 = go straight to RUN.
- DEPTH, 4096, number of words cleared by the sweep. 1 <= DEPTH <= 2^ADDR_W.

Ports:
- Clk  in  1  single clock; also drives BRAM Clk0.
- AsyncResetN  in  1  asynchronous active-low reset.
- Req0, Req1  in  1 each  request from client n; held until granted.
- We0, We1  in  1 each  1 = write, 0 = read.
- Addr0, Addr1  in  ADDR_W each  request address.
- WData0, WData1  in  DATA_W each  write data.
- Gnt0, Gnt1  out  1 each  request accepted this cycle.
- RValid0, RValid1  out  1 each  read data valid for client n.
- RData  out  DATA_W  read data; shared by both clients, qualified by RValid0/RValid1.
- BramAddr  out  ADDR_W  to BRAM AddressA.
- BramDataIn  out  DATA_W  to BRAM DataInA.
- BramWeRen  out  1  to BRAM WeRenA; 1 = write.
- BramClkEn  out  1  to BRAM ClkEn0; 1 only in a cycle that performs an access.
- BramDataOut  in  DATA_W  from BRAM DataOutA.
- Busy  out  1  high while the clear sweep runs.

Behaviour:
- FSM states: INIT, RUN.
  - Reset enters INIT if CLEAR_ON_RESET=1, otherwise RUN.
  - INIT → RUN after the write to address DEPTH-1.
- INIT:
  - Counter starts at 0. Each cycle: BramClkEn=1, BramWeRen=1, BramDataIn=0, BramAddr=counter; counter increments.
  - Busy=1; Gnt0=Gnt1=0 throughout.
  - Sweep takes exactly DEPTH cycles. Busy falls in the first RUN cycle.
- RUN arbitration (combinational grant, same cycle as the request):
  - Only Req0 asserted → Gnt0=1.
  - Only Req1 asserted → Gnt1=1.
  - Both asserted → grant the requester not recorded in the LastGnt register. LastGnt updates on every grant.
  - LastGnt resets to 1, so client 0 wins the first conflict.
  - At most one Gnt per cycle.
- BRAM drive in a granted cycle:
  - BramClkEn=1, BramAddr/BramDataIn/BramWeRen = the granted client's Addr/WData/We.
  - The access is performed at that clock edge.
  - With no grant: BramClkEn=0, BramWeRen=0; address/data hold their last values.
- Read return:
  - A granted read pushes {valid, id} into a READ_LAT-deep shift register.
  - RValid[id] is asserted exactly READ_LAT cycles after the Gnt cycle; RData = BramDataOut in that cycle.
  - Writes produce no RValid.
  - Back-to-back reads every cycle are supported; throughput is 1 access/cycle.
- Ordering: accesses are serialised in grant order. A read granted in the cycle after a write to the same address returns the new data (BRAM write-first is not required because the two accesses are in different cycles).
- Handshake: a client must hold Req/We/Addr/WData stable until Gnt. Dropping Req before Gnt is legal; the request is simply withdrawn.
- Reset values: Gnt0=Gnt1=0, RValid0=RValid1=0, RData=0, BramClkEn=0, BramWeRen=0, BramAddr=0, BramDataIn=0.
  - Busy=CLEAR_ON_RESET.
  - Sweep counter=0; LastGnt=1; read pipeline cleared.
- Reset mid-operation: in-flight reads are discarded (no RValid) and the sweep restarts from address 0.

Optional Feature:
- Macro: ALTA_BRAM_ARB_STATS_EN.
- Defined:
  - Adds output ConflictCnt[15:0]: increments by 1 in each RUN cycle with Req0 && Req1; saturates at 16'hFFFF.
  - Adds input ConflictClr: synchronous clear to 0, with priority over the increment.
  - ConflictCnt resets to 0.
- Undefined: ports and counter are absent; all other behaviour is identical.

Test Plan:
- Clear sweep: CLEAR_ON_RESET=1, DEPTH=16, release reset → Busy high exactly 16 cycles, BRAM writes to addrs 0..15 with data 0; then a read of addr 5 returns 0.
- Single client: Req0 write 0x2A5A5 @0x010, next cycle Req0 read @0x010 → Gnt0 in each cycle; RValid0 READ_LAT cycles after the read's Gnt with RData=0x2A5A5.
- Conflict round robin: Req0 and Req1 held for 4 cycles (reads @0x001 and @0x002) → grant order 0,1,0,1; RValid0/RValid1 alternate with the correct data for each address.
- Latency 2: READ_LAT=2, reads granted every cycle → RValid is a continuous stream 2 cycles behind the grants, with ids and data matching.
- Reset mid-read: assert AsyncResetN=0 one cycle after a read Gnt → no RValid appears; all outputs at reset values immediately (asynchronously).
- With ALTA_BRAM_ARB_STATS_EN: 3 conflict cycles → ConflictCnt=3; pulse ConflictClr during a conflict cycle → ConflictCnt=0 next cycle.
